cellrv32_npu_instr_serializer: RTL
==================================

# cellrv32_npu_instr_serializer

Transmit-side counterpart of the NPU instruction decoder. Accepts one packed `instruction_t` per handshake and packs it into the canonical 80-bit instruction bit image, opcode in the LSBs. Streams that image as fixed-width words, least-significant word first, over a valid/ready link into the NPU instruction FIFO. This lets the CPU-side issue path build instructions field-wise and guarantees the decoder reconstructs them bit-exact.

## Interface
Parameters:
- `WORD_WIDTH`, default 32: link word width. Legal values are 16, 32 and 64.
- `NUM_WORDS`, default ceil(INSTRUCTION_WIDTH/WORD_WIDTH) = 3: derived; not to be overridden.

Ports:
- `clk_i`  in  1: clock. Single clock domain, rising edge.
- `rst_i`  in  1: reset. Synchronous, active-high.
- `instr_valid_i`  in  1: `instr_i` holds a valid instruction.
- `instr_i`  in  INSTRUCTION_WIDTH (80): `instruction_t` {opcode, calc_len, acc_addr, buff_addr}.
- `instr_ready_o`  out  1: serializer can accept an instruction this cycle.
- `word_valid_o`  out  1: `word_o` valid.
- `word_o`  out  WORD_WIDTH: current instruction word.
- `word_last_o`  out  1: `word_o` is the final word of the instruction.
- `word_ready_i`  in  1: downstream accepts `word_o`.
- `busy_o`  out  1: an instruction is held (state SEND).
- `sent_count_o`  out  16: number of fully transmitted instructions, wraps modulo 2^16.

## Operation
- **Packing:** the exact inverse of `bits_to_instruction`.
  - bits[7:0] = opcode
  - bits[39:8] = calc_len
  - bits[55:40] = acc_addr
  - bits[79:56] = buff_addr
- **Word k:** bits[k*WORD_WIDTH +: WORD_WIDTH], with bits above 79 zero-filled (for W=32, word2[31:16] = 0).
- **FSM states:** IDLE and SEND.
  - IDLE: `instr_ready_o` = 1. On `instr_valid_i`, latch the packed image into `shreg`, set `idx` = 0, and go to SEND.
  - SEND: `word_valid_o` = 1 and `word_o` = `shreg[WORD_WIDTH-1:0]`. On `word_ready_i`, shift `shreg` right by WORD_WIDTH and increment `idx`.
  - `word_last_o` = (`idx` == NUM_WORDS-1).
  - On the last accepted word, increment `sent_count_o`. If `instr_valid_i` is high in that same cycle, load the new instruction and stay in SEND with `idx` = 0 (back-to-back). Otherwise return to IDLE.
- **`instr_ready_o`:** 1 in IDLE, or in SEND when `word_last_o` & `word_ready_i`. This is a combinational path from `word_ready_i` and is intended.
- **`busy_o`:** equals (state == SEND).
- **Upstream stall:** `instr_i` is sampled only on handshake. Changes while not ready are ignored.
- **Downstream stall:** `word_ready_i` low holds `word_o`, `word_last_o` and `idx` stable. `word_valid_o` never deasserts mid-instruction.

## Timing
- **Reset:** state IDLE; `instr_ready_o` = 1; `word_valid_o` = 0; `word_o` = 0; `word_last_o` = 0; `busy_o` = 0; `sent_count_o` = 0; `shreg` = 0; `idx` = 0.
- **Reset mid-SEND:** the partial instruction is discarded and no further words are emitted. Downstream is responsible for resynchronizing, since the instruction FIFO is reset alongside.
- **Latency:** instruction handshake in cycle N gives word0 valid in cycle N+1. With `word_ready_i` held high, the last word is accepted in cycle N+NUM_WORDS.
- **Throughput:** one word per cycle sustained. Back-to-back instructions have no bubble, so 3 cycles per instruction at W=32.
- **Counter:** `sent_count_o` updates in the cycle after the last-word handshake. 16'hFFFF wraps to 0.

## Structure
- **Package additions** (`cellrv32_npu_package`):
  - `INSTR_LINK_WIDTH` = 32
  - `INSTR_NUM_WORDS` constant
  - function `instruction_to_bits(instruction_t)`, the inverse of `bits_to_instruction`, reused by this block and by the testbench scoreboard
  - serializer state enum `instr_ser_state_t`
- **Sub-modules:** none; a single flat module, estimated at about 150 lines.

## Test plan
All vectors at W=32.
- **Single instruction:** opcode=8'hA5, calc_len=32'h12345678, acc_addr=16'hBEEF, buff_addr=24'hC0FFEE, `word_ready_i`=1.
  - Response: words 32'h345678A5, 32'hEEBEEF12, 32'h0000C0FF on cycles N+1..N+3, `word_last_o` only on the third, `sent_count_o`=1.
- **Downstream stall:** same instruction, `word_ready_i` low for 4 cycles during word1.
  - Response: 32'hEEBEEF12 held stable with `word_valid_o`=1 and `instr_ready_o`=0 throughout.
- **Back-to-back:** two instructions (opcode 8'h01, then 8'h02) with `instr_valid_i` constantly high.
  - Response: 6 consecutive words with no bubble; second instruction accepted in the cycle of the first's last word.
- **Round-trip:** 1000 random instructions with random `word_ready_i`, words reassembled and passed through `bits_to_instruction`.
  - Response: every struct equal to its input; `sent_count_o`=1000.
- **Reset mid-SEND:** `rst_i` asserted after word0 accepted.
  - Response: next cycle `word_valid_o`=0, `instr_ready_o`=1, `sent_count_o`=0; a new instruction then starts cleanly at word0.
- **Wrap:** force 65536 instructions.
  - Response: `sent_count_o` returns to 16'h0000.

Source files
------------

// File: rtl/cellrv32_npu_package.sv
// cellrv32_npu_package: NPU instruction format, link sizing and bit-image conversion helpers
package cellrv32_npu_package;
  localparam int INSTRUCTION_WIDTH = 80;
  localparam int INSTR_LINK_WIDTH = 32;
  localparam int INSTR_NUM_WORDS = (INSTRUCTION_WIDTH + INSTR_LINK_WIDTH - 1) / INSTR_LINK_WIDTH;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] calc_len;
    logic [15:0] acc_addr;
    logic [23:0] buff_addr;
  } instruction_t;
  typedef enum logic {SER_IDLE, SER_SEND} instr_ser_state_t;
  function automatic instruction_t bits_to_instruction(input logic [INSTRUCTION_WIDTH-1:0] b);
    instruction_t i;
    i.opcode    = b[7:0];
    i.calc_len  = b[39:8];
    i.acc_addr  = b[55:40];
    i.buff_addr = b[79:56];
    return i;
  endfunction
  // Image order is the reverse of the struct order: opcode lands in the LSBs
  function automatic logic [INSTRUCTION_WIDTH-1:0] instruction_to_bits(input instruction_t i);
    return {i.buff_addr, i.acc_addr, i.calc_len, i.opcode};
  endfunction
endpackage

// File: rtl/cellrv32_npu_instr_serializer.sv
// cellrv32_npu_instr_serializer: packs instruction_t into its bit image and streams it LSW-first
module cellrv32_npu_instr_serializer
  import cellrv32_npu_package::*;
#(
  parameter int WORD_WIDTH = INSTR_LINK_WIDTH,
  parameter int NUM_WORDS = (INSTRUCTION_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         instr_valid_i,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_i,
  output logic                         instr_ready_o,
  output logic                         word_valid_o,
  output logic [WORD_WIDTH-1:0]        word_o,
  output logic                         word_last_o,
  input  logic                         word_ready_i,
  output logic                         busy_o,
  output logic [15:0]                  sent_count_o
);
  localparam int SHREG_WIDTH = NUM_WORDS * WORD_WIDTH;
  localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  instr_ser_state_t state, state_nxt;
  logic [SHREG_WIDTH-1:0] shreg, shreg_nxt;
  logic [IDX_WIDTH-1:0] idx, idx_nxt;
  logic [15:0] sent_count;
  logic word_fire, last_fire;
  always_comb begin
    busy_o = state == SER_SEND;
    word_valid_o = busy_o;
    word_o = shreg[WORD_WIDTH-1:0];
    word_last_o = busy_o && idx == IDX_WIDTH'(NUM_WORDS - 1);
    word_fire = busy_o && word_ready_i;
    last_fire = word_last_o && word_ready_i;
    instr_ready_o = !busy_o || last_fire;
    shreg_nxt = word_fire ? shreg >> WORD_WIDTH : shreg;
    idx_nxt = last_fire ? '0 : word_fire ? idx + 1'b1 : idx;
    state_nxt = last_fire ? SER_IDLE : state;
    // A load in the last-word cycle overrides the return to idle: back-to-back with no bubble
    if (instr_ready_o && instr_valid_i) begin
      shreg_nxt = SHREG_WIDTH'(instruction_to_bits(instruction_t'(instr_i)));
      idx_nxt = '0;
      state_nxt = SER_SEND;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= SER_IDLE;
      shreg <= '0;
      idx <= '0;
      sent_count <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      idx <= idx_nxt;
      sent_count <= sent_count + 16'(last_fire);
    end
  end
  assign sent_count_o = sent_count;
endmodule
